trap_unit: RTL and testbench
============================

// Module: trap_unit
// PURPOSE
//  Parametrised trap controller for the rv32 cores. It takes over exception/interrupt handling from the control path.
//  - Gathers synchronous exceptions from decode and NUM_IRQ interrupt lines.
//  - Prioritises them, registers cause/epc and pulses a PC redirect to the trap vector.
//  - Tracks handler state until sret, then pulses a return redirect.
// PARAMETERS
//  XLEN       32   datapath / cause / epc width
//  NUM_IRQ    8    interrupt lines, legal range 1..16
//  EDGE_MASK  '0   NUM_IRQ bits; per line: 1 = rising-edge latched, 0 = level
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous reset, active-high
//  stall           in   1        core stalled; no trap or return commits this cycle
//  exc_illegal     in   1        illegal instruction / invalid CSR
//  exc_privileged  in   1        privilege violation
//  exc_syscall     in   1        scall
//  exc_sbreak      in   1        sbreak
//  sret            in   1        sret decoded
//  inst_pc         in   XLEN     PC of the current instruction
//  irq             in   NUM_IRQ  raw interrupt lines, synchronous to clk
//  irq_en          in   NUM_IRQ  interrupt mask (im)
//  irq_clr         in   NUM_IRQ  write-1-clear for edge-latched pending bits
//  global_ei       in   1        status.ei
//  trap_valid      out  1        1-cycle pulse: redirect PC to evec
//  ret_valid       out  1        1-cycle pulse: redirect PC to epc
//  cause           out  XLEN     registered trap cause
//  epc             out  XLEN     registered exception PC
//  ip              out  NUM_IRQ  registered pending vector
//  in_handler      out  1        1 while state is TRAP or HANDLER
// BEHAVIOUR
//  Reset: every output 0, state IDLE, ip 0, irq history 0. Reset mid-trap aborts to IDLE; no pulse is emitted that cycle.
//  Pending bits, updated every cycle:
//  - Level line: ip[i] <= irq[i].
//  - Edge line: ip[i] <= 1 on irq[i] & ~irq_q[i]; else 0 on irq_clr[i]. Set beats clear in the same cycle.
//  - irq_clr has no effect on level lines.
//  int_req = global_ei & |(ip & irq_en). Uses registered ip, so +1 cycle from irq.
//  Priority: interrupt > illegal > privileged > syscall > sbreak. Lowest irq index wins.
//  Cause codes:
//  - illegal = 2, privileged = 3, syscall = 6, sbreak = 7.
//  - interrupt = {1'b1, index zero-extended to XLEN-1 bits}.
//  FSM with states IDLE, TRAP, HANDLER, RET:
//  - IDLE: on !stall & (any exc_* | int_req), latch cause and epc <= inst_pc, go to TRAP. Under stall nothing is latched.
//  - TRAP: trap_valid = 1 for exactly one cycle, then HANDLER.
//  - HANDLER: interrupts are ignored, whatever global_ei is. On !stall & any exc_*: re-latch cause/epc, go to TRAP.
//    Else on !stall & sret: go to RET. An exception beats sret in the same cycle.
//  - RET: ret_valid = 1 for one cycle, then IDLE. Interrupts are accepted from the first IDLE cycle.
//  sret while in IDLE is ignored (privilege checking is decode's job).
//  Latency: trap_valid is high the cycle after the qualifying condition. cause/epc are valid from that cycle and held until the next trap.
//  trap_valid and ret_valid are never high together.
// TESTING
//  1. Reset with irq = 8'hFF, level lines -> all outputs 0 during reset; ip = 8'hFF one cycle after release.
//  2. IDLE, inst_pc = 32'h100, exc_illegal = 1 with stall = 1 for 2 cycles, then 0 -> trap_valid only after stall drops;
//     cause = 2, epc = 32'h100, single pulse.
//  3. EDGE_MASK = 8'h01, irq[0] pulses 1 cycle, irq_en = 1, global_ei = 1 -> ip[0] stays set;
//     trap_valid with cause = 32'h8000_0000; irq_clr[0] clears ip[0].
//  4. irq[5] and irq[2] pending and enabled, exc_syscall = 1 in the same cycle -> cause = 32'h8000_0002.
//  5. In HANDLER, irq[1] asserted -> no trap. sret -> ret_valid for 1 cycle, then IDLE, then trap cause = 32'h8000_0001.
//  6. In HANDLER, exc_sbreak and sret together -> trap_valid, cause = 7, no ret_valid. rst asserted in TRAP -> IDLE, outputs 0.

Source files
------------

// File: rtl/trap_unit.sv
// trap_unit: gathers decode exceptions and interrupt lines, prioritises them,
// registers cause/epc, pulses a trap redirect, and tracks the handler until sret.
module trap_unit #(
   parameter int                   XLEN      = 32,
   parameter int                   NUM_IRQ   = 8,
   parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               exc_illegal,
   input  logic               exc_privileged,
   input  logic               exc_syscall,
   input  logic               exc_sbreak,
   input  logic               sret,
   input  logic [XLEN-1:0]    inst_pc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_en,
   input  logic [NUM_IRQ-1:0] irq_clr,
   input  logic               global_ei,
   output logic               trap_valid,
   output logic               ret_valid,
   output logic [XLEN-1:0]    cause,
   output logic [XLEN-1:0]    epc,
   output logic [NUM_IRQ-1:0] ip,
   output logic               in_handler
);

   // Interrupt index needs 4 bits for up to 16 lines.
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {IDLE, TRAP, HANDLER, RET} state_t;

   state_t             state, state_nxt;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] ip_nxt;
   logic [NUM_IRQ-1:0] pend_en;
   logic               exc_any;
   logic               int_req;
   logic               take_trap;
   logic [IDX_W-1:0]   irq_idx;
   logic [XLEN-1:0]    exc_cause;
   logic [XLEN-1:0]    trap_cause;

   assign exc_any = exc_illegal | exc_privileged | exc_syscall | exc_sbreak;
   assign pend_en = ip & irq_en;
   assign int_req = global_ei & (|pend_en);

   // Pending vector next value: level lines follow irq, edge lines latch rising edges.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
      ip_nxt = ip;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (EDGE_MASK[i]) begin
            if (irq[i] && !irq_q[i])
               ip_nxt[i] = 1'b1;   // set beats clear
            else if (irq_clr[i])
               ip_nxt[i] = 1'b0;
         end else begin
            ip_nxt[i] = irq[i];
         end
      end
   end

   // Pending vector and irq history registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         ip    <= '0;
         irq_q <= '0;
      end else begin
         ip    <= ip_nxt;
         irq_q <= irq;
      end
   end

   // Cause selection: lowest enabled pending interrupt, then exceptions by fixed priority.
   always_comb begin
      irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend_en[i])
            irq_idx = IDX_W'(i);
      end

      if (exc_illegal)         exc_cause = XLEN'(2);
      else if (exc_privileged) exc_cause = XLEN'(3);
      else if (exc_syscall)    exc_cause = XLEN'(6);
      else                     exc_cause = XLEN'(7);

      // Interrupts only count in IDLE; HANDLER sees exceptions only.
      if (state == IDLE && int_req) begin
         trap_cause              = '0;
         trap_cause[XLEN-1]      = 1'b1;
         trap_cause[IDX_W-1:0]   = irq_idx;
      end else begin
         trap_cause = exc_cause;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; take_trap marks the cycle cause/epc are captured.
   always_comb begin
      state_nxt = state;
      take_trap = 1'b0;
      case (state)
         IDLE: begin
            if (!stall && (exc_any || int_req)) begin
               take_trap = 1'b1;
               state_nxt = TRAP;
            end
         end
         TRAP:    state_nxt = HANDLER;
         HANDLER: begin
            if (!stall && exc_any) begin
               take_trap = 1'b1;
               state_nxt = TRAP;
            end else if (!stall && sret) begin
               state_nxt = RET;
            end
         end
         RET:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Cause / exception PC capture, held until the next trap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cause <= '0;
         epc   <= '0;
      end else if (take_trap) begin
         cause <= trap_cause;
         epc   <= inst_pc;
      end
   end

   // Moore outputs, forced low while reset is asserted so an aborted trap emits no pulse.
   always_comb begin
      trap_valid = (state == TRAP) && !rst;
      ret_valid  = (state == RET) && !rst;
      in_handler = (state == TRAP || state == HANDLER) && !rst;
   end

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed scenarios plus randomized traffic, every cycle checked
// against a behavioural model of the trap controller.
module tb_trap_unit;

   localparam int         XLEN  = 32;
   localparam int         NIRQ  = 8;
   localparam logic [7:0] EDGE  = 8'h01;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic            exc_illegal, exc_privileged, exc_syscall, exc_sbreak;
   logic            sret;
   logic [31:0]     inst_pc;
   logic [7:0]      irq, irq_en, irq_clr;
   logic            global_ei;
   logic            trap_valid, ret_valid, in_handler;
   logic [31:0]     cause, epc;
   logic [7:0]      ip;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: pending bits, irq history, a pulse flag each for trap and
   // return redirects, and a busy flag covering "trap taken, sret not yet seen".
   logic [7:0]  m_ip, m_irq_q;
   logic [31:0] m_cause, m_epc;
   logic        m_trap_pulse, m_ret_pulse, m_busy;

   trap_unit #(.XLEN(XLEN), .NUM_IRQ(NIRQ), .EDGE_MASK(EDGE)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .exc_illegal(exc_illegal), .exc_privileged(exc_privileged),
      .exc_syscall(exc_syscall), .exc_sbreak(exc_sbreak),
      .sret(sret), .inst_pc(inst_pc),
      .irq(irq), .irq_en(irq_en), .irq_clr(irq_clr), .global_ei(global_ei),
      .trap_valid(trap_valid), .ret_valid(ret_valid),
      .cause(cause), .epc(epc), .ip(ip), .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_take(input bit use_irq);
      m_trap_pulse = 1'b1;
      m_busy       = 1'b1;
      m_epc        = inst_pc;
      if (use_irq) begin
         m_cause = 32'h0;
         for (int i = NIRQ - 1; i >= 0; i--)
            if (m_ip[i] && irq_en[i]) m_cause = 32'h8000_0000 + i;
      end else if (exc_illegal)    m_cause = 2;
      else if (exc_privileged)     m_cause = 3;
      else if (exc_syscall)        m_cause = 6;
      else                         m_cause = 7;
   endtask

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      bit exc, irq_hit;
      logic [7:0] new_ip;
      if (rst) begin
         m_ip = 0; m_irq_q = 0; m_cause = 0; m_epc = 0;
         m_trap_pulse = 0; m_ret_pulse = 0; m_busy = 0;
         return;
      end
      exc     = exc_illegal | exc_privileged | exc_syscall | exc_sbreak;
      irq_hit = global_ei && ((m_ip & irq_en) != 0);
      if (m_trap_pulse)      m_trap_pulse = 0;
      else if (m_ret_pulse)  m_ret_pulse = 0;
      else if (!m_busy) begin
         if (!stall && (exc || irq_hit)) model_take(irq_hit);
      end else begin
         if (!stall && exc)       model_take(1'b0);
         else if (!stall && sret) begin m_busy = 0; m_ret_pulse = 1; end
      end
      for (int i = 0; i < NIRQ; i++) begin
         if (EDGE[i]) new_ip[i] = (irq[i] && !m_irq_q[i]) ? 1'b1 : (irq_clr[i] ? 1'b0 : m_ip[i]);
         else         new_ip[i] = irq[i];
      end
      m_ip    = new_ip;
      m_irq_q = irq;
   endtask

   task automatic check_all();
      check("trap_valid", 32'(trap_valid), 32'(m_trap_pulse & !rst));
      check("ret_valid",  32'(ret_valid),  32'(m_ret_pulse & !rst));
      check("in_handler", 32'(in_handler), 32'(m_busy & !rst));
      check("cause", cause, m_cause);
      check("epc",   epc,   m_epc);
      check("ip",    32'(ip), 32'(m_ip));
      check("exclusive", 32'(trap_valid & ret_valid), 32'h0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst = 1; stall = 0; exc_illegal = 0; exc_privileged = 0; exc_syscall = 0;
      exc_sbreak = 0; sret = 0; inst_pc = 0; irq = 8'hFF; irq_en = 0; irq_clr = 0;
      global_ei = 0;
      m_ip = 0; m_irq_q = 0; m_cause = 0; m_epc = 0;
      m_trap_pulse = 0; m_ret_pulse = 0; m_busy = 0;

      // 1: reset with all lines high, outputs zero, ip follows one cycle after release
      cycle(); cycle();
      check("t1_rst_ip", 32'(ip), 32'h0);
      check("t1_rst_cause", cause, 32'h0);
      rst = 0;
      cycle();
      check("t1_ip", 32'(ip), 32'hFF);

      // 2: stalled illegal instruction commits only when stall drops
      irq = 0; irq_clr = 8'h01;
      cycle();
      irq_clr = 0; inst_pc = 32'h100; exc_illegal = 1; stall = 1;
      cycle(); check("t2_stall0", 32'(trap_valid), 32'h0);
      cycle(); check("t2_stall1", 32'(trap_valid), 32'h0);
      stall = 0;
      cycle();
      check("t2_trap", 32'(trap_valid), 32'h1);
      check("t2_cause", cause, 32'd2);
      check("t2_epc", epc, 32'h100);
      exc_illegal = 0;
      cycle(); check("t2_single", 32'(trap_valid), 32'h0);
      sret = 1; cycle(); check("t2_ret", 32'(ret_valid), 32'h1);
      sret = 0; cycle(); check("t2_idle", 32'(in_handler), 32'h0);

      // 3: edge line 0 latched from a one-cycle pulse, then cleared by irq_clr
      irq_en = 8'h01; global_ei = 1; irq = 8'h01;
      cycle();
      irq = 0;
      cycle();
      check("t3_trap", 32'(trap_valid), 32'h1);
      check("t3_cause", cause, 32'h8000_0000);
      check("t3_ip_held", 32'(ip[0]), 32'h1);
      irq_clr = 8'h01;
      cycle(); check("t3_ip_clr", 32'(ip[0]), 32'h0);
      irq_clr = 0; sret = 1; cycle();
      sret = 0; cycle(); cycle();
      check("t3_no_retrap", 32'(in_handler), 32'h0);

      // 4: interrupts 5 and 2 beat a simultaneous syscall, lowest index wins
      global_ei = 0; irq_en = 8'hFF; irq = 8'h24;
      cycle();
      exc_syscall = 1; global_ei = 1; inst_pc = 32'h204;
      cycle();
      check("t4_cause", cause, 32'h8000_0002);
      exc_syscall = 0;
      cycle();

      // 5: interrupt ignored in handler, taken right after return
      irq = 8'h02;
      cycle(); cycle();
      check("t5_no_trap", 32'(trap_valid), 32'h0);
      check("t5_in_handler", 32'(in_handler), 32'h1);
      sret = 1; cycle(); check("t5_ret", 32'(ret_valid), 32'h1);
      sret = 0; cycle(); check("t5_idle", 32'(ret_valid), 32'h0);
      cycle();
      check("t5_trap", 32'(trap_valid), 32'h1);
      check("t5_cause", cause, 32'h8000_0001);

      // 6: sbreak beats sret in handler; reset during TRAP aborts the pulse
      irq = 0;
      cycle();
      exc_sbreak = 1; sret = 1; inst_pc = 32'h300;
      cycle();
      check("t6_trap", 32'(trap_valid), 32'h1);
      check("t6_cause", cause, 32'd7);
      check("t6_no_ret", 32'(ret_valid), 32'h0);
      exc_sbreak = 0; sret = 0;
      cycle();
      exc_syscall = 1;
      cycle();
      exc_syscall = 0; rst = 1;
      #1;
      check("t6_rst_pulse", 32'(trap_valid), 32'h0);
      check("t6_rst_handler", 32'(in_handler), 32'h0);
      cycle();
      check("t6_rst_cause", cause, 32'h0);
      check("t6_rst_epc", epc, 32'h0);
      rst = 0;
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst            = ($urandom_range(0, 399) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         exc_illegal    = ($urandom_range(0, 15) == 0);
         exc_privileged = ($urandom_range(0, 15) == 0);
         exc_syscall    = ($urandom_range(0, 15) == 0);
         exc_sbreak     = ($urandom_range(0, 15) == 0);
         sret           = ($urandom_range(0, 4) == 0);
         inst_pc        = $urandom & 32'hFFFF_FFFC;
         irq            = 8'($urandom & $urandom & $urandom);
         irq_en         = 8'($urandom);
         irq_clr        = 8'($urandom & $urandom);
         global_ei      = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
